a51_cipher_stream: RTL and testbench

Downstream of the A5/1 keystream generator. Takes the serial keystream (one bit per accepted cycle) and packs it into bytes. Each byte is XORed with the matching plaintext/ciphertext byte from the message store, and the result is pushed through a small byte FIFO to the LCD writer with a valid/ready handshake. Backpressure to the keygen is via ks_ready, which the top ANDs into the keygen counter enable, so no keystream bit is ever lost.

---
 rtl/a51_pkg.sv | 25 ++
 rtl/a51_byte_fifo.sv | 106 ++++++++++
 rtl/a51_cipher_stream.sv | 151 +++++++++++++++
 tb/tb_a51_cipher_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a51_pkg
//  Description : Shared constants and types for the A5/1 keystream cipher
//                stream path (message size, key/frame sizes, FSM states,
//                byte type).
//  Revision    : 1.0  initial release
// ============================================================================
package a51_pkg;

    localparam int A51_MSG_BYTES  = 28;
    localparam int A51_KEY_BITS   = 64;
    localparam int A51_FRAME_BITS = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } a51_state_t;

    typedef logic [7:0] a51_byte_t;

endpackage
`default_nettype wire

// File: rtl/a51_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : a51_byte_fifo
//  Description : Synchronous byte FIFO with registered head output (zero when
//                empty), simultaneous push/pop (also when full) and flush.
//                Asynchronously cleared by clrn.
//  Revision    : 1.0  initial release
// ============================================================================
module a51_byte_fifo
    import a51_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      clrn,
    input  logic      i_flush,
    input  logic      i_push,
    input  a51_byte_t i_push_data,
    input  logic      i_pop,
    output a51_byte_t o_head,
    output logic      o_empty,
    output logic      o_full,
    output logic      o_empty_next
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    a51_byte_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   w_rd_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    a51_byte_t            r_head;
    a51_byte_t            w_head_next;
    logic                 w_push;
    logic                 w_pop;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == c_full_cnt);
    assign o_head       = r_head;
    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign w_pop        = i_pop & ~o_empty;
    assign w_push       = i_push & (~o_full | w_pop);
    assign w_rd_next    = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
    assign o_empty_next = (w_count_next == '0);

    // Occupancy after this edge.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    // Head after this edge; bypass the write data when the pushed byte
    // becomes the head (push into empty, or push+pop with one entry).
    always_comb begin
        w_head_next = '0;
        if (w_count_next == '0) begin
            w_head_next = '0;
        end else if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_head  <= w_head_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/a51_cipher_stream.sv
`default_nettype none
// ============================================================================
//  Module      : a51_cipher_stream
//  Description : Packs the serial A5/1 keystream into bytes, XORs each byte
//                with the matching message byte and queues the result for the
//                LCD writer through a small byte FIFO with valid/ready.
//                Backpressure to the keystream generator via ks_ready.
//                Build option A51_LSB_FIRST_EN: the first keystream bit of a
//                byte lands in bit 0 instead of bit 7.
//  Revision    : 1.0  initial release
// ============================================================================
module a51_cipher_stream
    import a51_pkg::*;
#(
    parameter int NUM_BYTES  = A51_MSG_BYTES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         start,
    input  logic                         ks_bit,
    input  logic                         ks_valid,
    output logic                         ks_ready,
    output logic [$clog2(NUM_BYTES)-1:0] msg_index,
    input  logic [7:0]                   msg_byte,
    output logic [7:0]                   ct_data,
    output logic                         ct_valid,
    input  logic                         ct_ready,
    output logic                         done,
    output logic                         overrun
);

    localparam int c_idx_w = $clog2(NUM_BYTES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_BYTES - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    a51_state_t          r_state;
    a51_state_t          w_state_next;
    logic [2:0]          r_bit_cnt;
    logic [c_idx_w-1:0]  r_msg_index;
    a51_byte_t           r_shift;
    a51_byte_t           w_shift_next;
    logic                r_overrun;
    logic                r_done;
    logic                w_ks_ready;
    logic                w_accept;
    logic                w_byte_end;
    logic                w_pop;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_fifo_empty_next;
    a51_byte_t           w_fifo_head;

    // Only registered state feeds ks_ready; the last bit of a byte is held
    // off while the FIFO has no room for the byte it would complete.
    assign w_ks_ready = (r_state == COLLECT) & ~(w_fifo_full & (r_bit_cnt == 3'd7));
    // Bits presented together with start are dropped.
    assign w_accept   = ks_valid & w_ks_ready & ~start;
    assign w_byte_end = w_accept & (r_bit_cnt == 3'd7);
    assign w_pop      = ~w_fifo_empty & ct_ready;

`ifdef A51_LSB_FIRST_EN
    assign w_shift_next = {ks_bit, r_shift[7:1]};
`else
    assign w_shift_next = {r_shift[6:0], ks_bit};
`endif

    assign ks_ready  = w_ks_ready;
    assign msg_index = r_msg_index;
    assign ct_data   = w_fifo_head;
    assign ct_valid  = ~w_fifo_empty;
    assign done      = r_done;
    assign overrun   = r_overrun;

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == DONE);
        end
    end

    // FSM next state; start restarts from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (w_byte_end && (r_msg_index == c_last_idx)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty_next) begin
                    w_state_next = DONE;
                end
            end
            IDLE, DONE: w_state_next = r_state;
            default:    w_state_next = IDLE;
        endcase
        if (start) begin
            w_state_next = COLLECT;
        end
    end

    // Bit assembly, byte index and sticky overrun flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt   <= 3'd0;
            r_msg_index <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
        end else if (start) begin
            r_bit_cnt   <= 3'd0;
            r_msg_index <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                // Index holds on the final byte so it stays inside the store.
                if (w_byte_end && (r_msg_index != c_last_idx)) begin
                    r_msg_index <= r_msg_index + c_idx_one;
                end
            end
            if (ks_valid && ((r_state == DRAIN) || (r_state == DONE))) begin
                r_overrun <= 1'b1;
            end
        end
    end

    a51_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .clrn         (clrn),
        .i_flush      (start),
        .i_push       (w_byte_end),
        .i_push_data  (w_shift_next ^ msg_byte),
        .i_pop        (w_pop),
        .o_head       (w_fifo_head),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full),
        .o_empty_next (w_fifo_empty_next)
    );

endmodule
`default_nettype wire

// File: tb/tb_a51_cipher_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a51_cipher_stream
//  Description : Self-checking bench for a51_cipher_stream: single-byte
//                vector table, full-message runs against a reference model
//                (directed and randomized), restart, overrun and reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_a51_cipher_stream;

    localparam int NB = 28;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       clrn;
    logic       start;
    logic       ks_bit;
    logic       ks_valid;
    logic       ks_ready;
    logic [4:0] msg_index;
    logic [7:0] msg_byte;
    logic [7:0] ct_data;
    logic       ct_valid;
    logic       ct_ready;
    logic       done;
    logic       overrun;

    logic [7:0] msg_mem [0:31];
    int         n_pass  = 0;
    int         n_total = 0;

    assign msg_byte = msg_mem[msg_index];

    always #5 clk = ~clk;

    a51_cipher_stream #(
        .NUM_BYTES  (NB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .ks_bit    (ks_bit),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .msg_index (msg_index),
        .msg_byte  (msg_byte),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .done      (done),
        .overrun   (overrun)
    );

    typedef struct {
        logic [7:0] stream;   // stream[7] is the first bit sent
        logic [7:0] msg;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Byte value built from eight bits given in arrival order (s[7] first).
    function automatic logic [7:0] pack_bits(input logic [7:0] s);
        logic [7:0] r;
`ifdef A51_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = s[7-i];
`else
        r = s;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic v);
        start    = 1'b1;
        ks_valid = v;
        ks_bit   = 1'b1;
        step();
        start    = 1'b0;
        ks_valid = 1'b0;
    endtask

    // Whole message against the model. mode 0: all-ones keystream, 'A'
    // message, no stalls. mode 1: random data, valid and ready with stall
    // bursts. mode 2: random data, reader stalled for the first 60 cycles.
    task automatic run_msg(input int mode);
        logic       kb [NB*8];
        logic [7:0] exp_ct [NB];
        logic [7:0] s;
        logic       v;
        logic       r;
        int         sent   = 0;
        int         popped = 0;
        int         cyc    = 0;
        int         outst;
        for (int k = 0; k < NB; k++) begin
            msg_mem[k] = (mode == 0) ? 8'h41 : 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                kb[8*k+i] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                s[7-i]    = kb[8*k+i];
            end
            exp_ct[k] = pack_bits(s) ^ msg_mem[k];
        end
        pulse_start(1'b0);
        while (popped < NB && cyc < 4000) begin
            outst = sent / 8 - popped;
            chk("ks_ready", 32'(ks_ready), 32'((sent < NB*8) && !(outst == FD && sent % 8 == 7)));
            chk("ct_valid", 32'(ct_valid), 32'(outst > 0));
            if (outst == 0) chk("ct_data_empty", 32'(ct_data), 32'd0);
            chk("done_early", 32'(done), 32'd0);
            if (sent < NB*8) chk("msg_index", 32'(msg_index), 32'(sent / 8));
            case (mode)
                0:       begin v = 1'b1; r = 1'b1; end
                1:       begin
                             v = ($urandom % 4) != 0;
                             r = ((cyc / 37) % 3 == 2) ? 1'b0 : (($urandom % 3) != 0);
                         end
                default: begin v = 1'b1; r = (cyc >= 60); end
            endcase
            ks_valid = v && (sent < NB*8);
            ks_bit   = (sent < NB*8) ? kb[sent] : 1'b0;
            ct_ready = r;
            if (ct_valid && ct_ready) begin
                chk("ct_data", 32'(ct_data), 32'(exp_ct[popped]));
                popped++;
            end
            if (ks_valid && ks_ready) sent++;
            step();
            cyc++;
        end
        if (popped < NB) begin
            n_total++;
            $display("FAIL msg_timeout: popped=%0d required=%0d", popped, NB);
        end
        ks_valid = 1'b0;
        ct_ready = 1'b0;
        chk("done_after_last_pop", 32'(done), 32'd1);
        chk("ks_ready_after_msg", 32'(ks_ready), 32'd0);
        chk("ct_valid_after_msg", 32'(ct_valid), 32'd0);
        chk("overrun_clean", 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [7:0] exp;
        vt[0] = '{8'b10100101, 8'h48, 8'hED, 8'hED};
        vt[1] = '{8'b10000000, 8'h00, 8'h80, 8'h01};
        vt[2] = '{8'b11111111, 8'h41, 8'hBE, 8'hBE};
        vt[3] = '{8'b00000000, 8'h5A, 8'h5A, 8'h5A};
        vt[4] = '{8'b11000000, 8'h00, 8'hC0, 8'h03};
        vt[5] = '{8'b00001111, 8'hFF, 8'hF0, 8'h0F};
        vt[6] = '{8'b01100001, 8'h33, 8'h52, 8'hB5};
        vt[7] = '{8'b10010011, 8'hC3, 8'h50, 8'h0A};
        for (int i = 0; i < 32; i++) msg_mem[i] = 8'h00;

        clrn = 1'b0; start = 1'b0; ks_bit = 1'b0; ks_valid = 1'b0; ct_ready = 1'b0;
        step();
        step();
        chk("rst_ks_ready",  32'(ks_ready),  32'd0);
        chk("rst_ct_valid",  32'(ct_valid),  32'd0);
        chk("rst_ct_data",   32'(ct_data),   32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_msg_index", 32'(msg_index), 32'd0);
        clrn = 1'b1;
        step();
        chk("idle_ks_ready", 32'(ks_ready), 32'd0);

        // Single-byte vectors; each restarts with a (dropped) bit in the
        // start cycle.
        for (int e = 0; e < 8; e++) begin
`ifdef A51_LSB_FIRST_EN
            exp = vt[e].exp_lsb;
`else
            exp = vt[e].exp_msb;
`endif
            msg_mem[0] = vt[e].msg;
            ct_ready   = 1'b1;
            pulse_start(1'b1);
            for (int i = 7; i >= 0; i--) begin
                ks_valid = 1'b1;
                ks_bit   = vt[e].stream[i];
                if (i == 7) chk("vec_ks_ready", 32'(ks_ready), 32'd1);
                if (i == 0) chk("vec_no_early_valid", 32'(ct_valid), 32'd0);
                step();
            end
            ks_valid = 1'b0;
            chk("vec_ct_valid",  32'(ct_valid),  32'd1);
            chk("vec_ct_data",   32'(ct_data),   32'(exp));
            chk("vec_msg_index", 32'(msg_index), 32'd1);
            step();
            chk("vec_valid_one_cycle", 32'(ct_valid), 32'd0);
        end

        // Full message, then overrun and asynchronous reset.
        run_msg(0);
        ks_valid = 1'b1;
        step();
        chk("overrun_set", 32'(overrun), 32'd1);
        repeat (3) step();
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("done_held",      32'(done),    32'd1);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_overrun",   32'(overrun),   32'd0);
        chk("arst_done",      32'(done),      32'd0);
        chk("arst_ks_ready",  32'(ks_ready),  32'd0);
        chk("arst_ct_valid",  32'(ct_valid),  32'd0);
        chk("arst_ct_data",   32'(ct_data),   32'd0);
        chk("arst_msg_index", 32'(msg_index), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        step();
        chk("idle_no_overrun", 32'(overrun), 32'd0);
        ks_valid = 1'b0;

        // Reader stall fills the FIFO; then start clears overrun.
        run_msg(2);
        ks_valid = 1'b1;
        step();
        chk("overrun_set2", 32'(overrun), 32'd1);
        pulse_start(1'b0);
        chk("start_clears_overrun", 32'(overrun), 32'd0);
        chk("start_clears_done",    32'(done),    32'd0);

        repeat (3) run_msg(1);

        // Restart in the middle of byte 10 with bytes still queued.
        pulse_start(1'b0);
        for (int b = 0; b < 83; b++) begin
            ks_valid = 1'b1;
            ks_bit   = 1'($urandom_range(0, 1));
            ct_ready = (b < 70);
            step();
        end
        ks_valid = 1'b0;
        chk("mid_msg_index", 32'(msg_index), 32'd10);
        chk("mid_ct_valid",  32'(ct_valid),  32'd1);
        msg_mem[0] = 8'h48;
        start = 1'b1; ks_valid = 1'b1; ks_bit = 1'b1;
        step();
        start = 1'b0; ks_valid = 1'b0;
        chk("restart_msg_index", 32'(msg_index), 32'd0);
        chk("restart_ct_valid",  32'(ct_valid),  32'd0);
        chk("restart_overrun",   32'(overrun),   32'd0);
        chk("restart_ks_ready",  32'(ks_ready),  32'd1);
        for (int i = 7; i >= 0; i--) begin
            ks_valid = 1'b1;
            ks_bit   = vt[0].stream[i];
            step();
        end
        ks_valid = 1'b0;
        chk("restart_ct_data", 32'(ct_data), 32'(vt[0].exp_msb));

        // Reset and start together: reset wins, block stays idle.
        clrn = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        step();
        chk("rst_beats_start", 32'(ks_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
